maze_run_controller: RTL

Run sequencer between the maze explorer FSM and the motor/motion unit. It accepts one move code at a time from the explorer and dispatches it to the motor through a valid/ready handshake, then waits for motion completion. It tracks heading and grid position on the 9x9 maze, counts dead-ends, declares success at the exit cell, and faults on out-of-bounds moves, illegal codes or step-budget exhaustion.

---
 rtl/maze_pkg.sv | 39 +++
 rtl/maze_pose_tracker.sv | 78 +++++++
 rtl/maze_run_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze explorer, the run controller and the bench:
// move codes, heading and error encodings, default grid geometry.
package maze_pkg;

  localparam logic [2:0] MV_STOP    = 3'd0;
  localparam logic [2:0] MV_FORWARD = 3'd1;
  localparam logic [2:0] MV_LEFT    = 3'd2;
  localparam logic [2:0] MV_RIGHT   = 3'd3;
  localparam logic [2:0] MV_U_TURN  = 3'd4;

  localparam logic [1:0] HDG_N = 2'd0;
  localparam logic [1:0] HDG_E = 2'd1;
  localparam logic [1:0] HDG_S = 2'd2;
  localparam logic [1:0] HDG_W = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_BOUNDS  = 2'd2;
  localparam logic [1:0] ERR_BUDGET  = 2'd3;

  localparam int DEF_ROWS      = 9;
  localparam int DEF_COLS      = 9;
  localparam int DEF_START_R   = 4;
  localparam int DEF_START_C   = 0;
  localparam int DEF_EXIT_R    = 4;
  localparam int DEF_EXIT_C    = 8;
  localparam int DEF_MAX_STEPS = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_MV,
    ST_ISSUE,
    ST_EXEC,
    ST_CHECK,
    ST_DONE,
    ST_FAULT
  } run_state_t;

endpackage

// File: rtl/maze_pose_tracker.sv
// Heading, position and move counters for the robot, updated once per finished
// motion; also flags a FORWARD that would leave the grid and arrival at the exit.
module maze_pose_tracker
  import maze_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int START_R = DEF_START_R,
  parameter int START_C = DEF_START_C,
  parameter int EXIT_R  = DEF_EXIT_R,
  parameter int EXIT_C  = DEF_EXIT_C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       update,
  input  logic [2:0] code,
  output logic [3:0] pos_row,
  output logic [3:0] pos_col,
  output logic [1:0] heading,
  output logic [3:0] deadends,
  output logic [7:0] steps,
  output logic       oob,
  output logic       at_exit
);

  localparam logic signed [4:0] ROW_MAX = 5'(ROWS - 1);
  localparam logic signed [4:0] COL_MAX = 5'(COLS - 1);

  logic signed [4:0] tgt_row;
  logic signed [4:0] tgt_col;

  // Signed 5-bit target so that stepping off row/col 0 shows up as -1
  always_comb begin
    tgt_row = {1'b0, pos_row};
    tgt_col = {1'b0, pos_col};
    case (heading)
      HDG_N:   tgt_row = tgt_row - 5'sd1;
      HDG_E:   tgt_col = tgt_col + 5'sd1;
      HDG_S:   tgt_row = tgt_row + 5'sd1;
      default: tgt_col = tgt_col - 5'sd1;
    endcase
  end

  assign oob = (code == MV_FORWARD) &&
               ((tgt_row < 5'sd0) || (tgt_row > ROW_MAX) ||
                (tgt_col < 5'sd0) || (tgt_col > COL_MAX));

  assign at_exit = (pos_row == 4'(EXIT_R)) && (pos_col == 4'(EXIT_C));

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      pos_row  <= 4'(START_R);
      pos_col  <= 4'(START_C);
      heading  <= HDG_E;
      deadends <= 4'd0;
      steps    <= 8'd0;
    end else if (update) begin
      case (code)
        MV_FORWARD: begin
          if (!oob) begin
            pos_row <= tgt_row[3:0];
            pos_col <= tgt_col[3:0];
            steps   <= steps + 8'd1;
          end
        end
        MV_LEFT:  heading <= heading - 2'd1;
        MV_RIGHT: heading <= heading + 2'd1;
        MV_U_TURN: begin
          heading <= heading + 2'd2;
          if (deadends != 4'd15) deadends <= deadends + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/maze_run_controller.sv
// Run sequencer: takes one move from the explorer, hands it to the motor over
// valid/ready, waits for completion, then checks for exit, budget or fault.
module maze_run_controller
  import maze_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int START_R   = DEF_START_R,
  parameter int START_C   = DEF_START_C,
  parameter int EXIT_R    = DEF_EXIT_R,
  parameter int EXIT_C    = DEF_EXIT_C,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mv_valid,
  input  logic [2:0] mv_code,
  output logic       mv_ready,
  output logic       mot_valid,
  output logic [2:0] mot_cmd,
  input  logic       mot_ready,
  input  logic       mot_done,
  output logic [3:0] pos_row,
  output logic [3:0] pos_col,
  output logic [1:0] heading,
  output logic [3:0] deadends,
  output logic [7:0] steps,
  output logic       busy,
  output logic       done,
  output logic [1:0] error
);

  run_state_t state;
  logic       idle_like;
  logic       pose_init;
  logic       pose_update;
  logic       fwd_oob;
  logic       at_exit;

  assign idle_like   = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAULT);
  assign pose_init   = idle_like && start;
  assign pose_update = (state == ST_EXEC) && mot_done;

  maze_pose_tracker #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .START_R (START_R),
    .START_C (START_C),
    .EXIT_R  (EXIT_R),
    .EXIT_C  (EXIT_C)
  ) u_pose (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (pose_init),
    .update   (pose_update),
    .code     (mot_cmd),
    .pos_row  (pos_row),
    .pos_col  (pos_col),
    .heading  (heading),
    .deadends (deadends),
    .steps    (steps),
    .oob      (fwd_oob),
    .at_exit  (at_exit)
  );

  // mot_cmd doubles as the latched move code for the pose update in EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mv_ready  <= 1'b0;
      mot_valid <= 1'b0;
      mot_cmd   <= MV_STOP;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          if (start) begin
            state    <= ST_WAIT_MV;
            mv_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= ERR_NONE;
          end
        end
        ST_WAIT_MV: begin
          if (mv_valid) begin
            mv_ready <= 1'b0;
            if (mv_code == MV_STOP) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (mv_code > MV_U_TURN) begin
              state <= ST_FAULT;
              busy  <= 1'b0;
              error <= ERR_ILLEGAL;
            end else begin
              state     <= ST_ISSUE;
              mot_valid <= 1'b1;
              mot_cmd   <= mv_code;
            end
          end
        end
        ST_ISSUE: begin
          if (mot_ready) begin
            state     <= ST_EXEC;
            mot_valid <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (mot_done) begin
            if (fwd_oob) begin
              state <= ST_FAULT;
              busy  <= 1'b0;
              error <= ERR_BOUNDS;
            end else begin
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (at_exit) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (steps == 8'(MAX_STEPS)) begin
            state <= ST_FAULT;
            busy  <= 1'b0;
            error <= ERR_BUDGET;
          end else begin
            state    <= ST_WAIT_MV;
            mv_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
